// File: rtl/tx_msg_arbiter.sv
// tx_msg_arbiter: round-robin share of the serial byte transmitter between
// NREQ message sources. A granted message is latched, then shifted out one
// byte at a time over the tx_cs/tx_busy handshake, then done pulses.
module tx_msg_arbiter #(
    parameter int NREQ         = 3,
    parameter int MAXLEN       = 16,
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [5*NREQ-1:0]        msg_len,
    input  logic [8*MAXLEN*NREQ-1:0] msg_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic [7:0]               tx_tch,
    output logic                     tx_cs,
    input  logic                     tx_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MW = 8 * MAXLEN;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, SENDING, SENDED, FINISH} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr;
    logic [MW-1:0] shbuf;
    logic [4:0]    count;
    logic [TW-1:0] tcnt;
    logic          abort;

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [MW-1:0] sel_data;
    logic [4:0]    sel_len;
    logic [4:0]    sel_cnt;
    logic          timeout;

    // Round-robin search: first requesting source after ptr, wrapping
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_vld && (i == j) && req[i]) begin
                    pick_vld = 1'b1;
                    pick_idx = PW'(i);
                end
            end
        end
    end

    // Select the winning source's message and clamp its length to MAXLEN
    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_data = msg_data[i*MW +: MW];
                sel_len  = msg_len[i*5 +: 5];
            end
        end
        sel_cnt = (int'(sel_len) > MAXLEN) ? 5'(MAXLEN) : sel_len;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; timeout fires on the BUSY_TIMEOUT-th idle SENDING cycle
    always_comb begin
        state_nxt = state;
        timeout   = (tcnt == TW'(BUSY_TIMEOUT - 1));
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = SEND;
            SEND: begin
                if (count == 5'd0)  state_nxt = FINISH;
                else if (!tx_busy)  state_nxt = SENDING;
            end
            SENDING: begin
                if (tx_busy)        state_nxt = SENDED;
                else if (timeout)   state_nxt = FINISH;
            end
            SENDED:  if (!tx_busy) state_nxt = SEND;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, message buffer, byte launch and timeout bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt    <= '0;
            ptr    <= PW'(NREQ - 1);
            shbuf  <= '0;
            count  <= '0;
            tcnt   <= '0;
            abort  <= 1'b0;
            tx_tch <= '0;
            tx_cs  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        ptr   <= pick_idx;
                        shbuf <= sel_data;
                        count <= sel_cnt;
                    end
                end
                SEND: begin
                    if (count != 5'd0 && !tx_busy) begin
                        tx_tch <= shbuf[7:0];
                        shbuf  <= shbuf >> 8;
                        count  <= count - 5'd1;
                        tx_cs  <= 1'b1;
                        tcnt   <= '0;
                    end
                end
                SENDING: begin
                    if (tx_busy) begin
                        tx_cs <= 1'b0;
                    end else if (timeout) begin
                        tx_cs <= 1'b0;
                        abort <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    gnt   <= '0;
                    abort <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Completion pulses are the single FINISH cycle, qualified by the grant
    always_comb begin
        done = (state == FINISH) ? gnt : '0;
        err  = (state == FINISH) && abort;
    end

endmodule

// File: tb/tb_tx_msg_arbiter.sv
// Directed bench for tx_msg_arbiter with a simple tx busy model.
module tb_tx_msg_arbiter;
    localparam int NREQ = 3, MAXLEN = 16, BT = 8, BUSY_LEN = 20;
    localparam int MW = 8 * MAXLEN;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NREQ-1:0]          req;
    logic [5*NREQ-1:0]        msg_len;
    logic [8*MAXLEN*NREQ-1:0] msg_data;
    logic [NREQ-1:0]          gnt, done;
    logic                     err;
    logic [7:0]               tx_tch;
    logic                     tx_cs, tx_busy;

    int checks = 0, errors = 0;

    // tx model: auto mode raises busy for BUSY_LEN cycles per strobe
    logic auto_en, force_busy, m_busy;
    int   m_cnt;
    assign tx_busy = auto_en ? m_busy : force_busy;

    always #5 clk = ~clk;

    tx_msg_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .req(req), .msg_len(msg_len), .msg_data(msg_data),
        .gnt(gnt), .done(done), .err(err), .tx_tch(tx_tch), .tx_cs(tx_cs), .tx_busy(tx_busy)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (auto_en) begin
            if (!m_busy && tx_cs) begin
                m_busy <= 1'b1;
                m_cnt  <= BUSY_LEN;
            end else if (m_busy) begin
                if (m_cnt == 1) m_busy <= 1'b0;
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: log launched bytes, grant order and completions
    logic [7:0]      byteq[$];
    logic [NREQ-1:0] gntq[$];
    logic [NREQ-1:0] doneq[$];
    logic            errq[$];
    int              cs_pulses = 0;
    logic            prev_cs = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;

    always @(negedge clk) begin
        if (tx_cs && !prev_cs) begin
            byteq.push_back(tx_tch);
            cs_pulses++;
        end
        prev_cs = tx_cs;
        if (gnt != '0 && prev_gnt == '0) gntq.push_back(gnt);
        prev_gnt = gnt;
        if (done != '0) begin
            doneq.push_back(done);
            errq.push_back(err);
            checks++;
            if ((done & ~gnt) != '0 || $countones(done) != 1) begin
                errors++;
                $display("FAIL done_onehot: done=%b gnt=%b", done, gnt);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        byteq.delete();
        gntq.delete();
        doneq.delete();
        errq.delete();
        cs_pulses = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 3'b111;
        msg_len = {5'd1, 5'd1, 5'd1};
        repeat (3) tick();
        checks += 5;
        if (gnt !== 3'b000)  begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", done); end
        if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (tx_cs !== 1'b0)  begin errors++; $display("FAIL reset_cs: got %b want 0", tx_cs); end
        if (tx_tch !== 8'h00) begin errors++; $display("FAIL reset_tch: got %h want 00", tx_tch); end
        req = '0;
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 3'b000) begin errors++; $display("FAIL idle_no_req_gnt: got %b want 000", gnt); end
        repeat (2) tick();
    endtask

    task automatic test_single();
        logic [7:0] exp [5] = '{8'h52, 8'h45, 8'h41, 8'h44, 8'h59};
        logic [7:0] got;
        bit gnt_ok, ok;
        clear_logs();
        msg_data[0 +: MW] = '0;
        msg_data[0 +: 40] = 40'h5944414552;
        msg_len[0 +: 5] = 5'd5;
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt_latency: got %b want 001", gnt); end
        tick();
        checks++;
        if (tx_cs !== 1'b1 || tx_tch !== 8'h52) begin
            errors++; $display("FAIL single_cs_latency: cs=%b tch=%h want cs=1 tch=52", tx_cs, tx_tch);
        end
        gnt_ok = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (done != '0) begin ok = 1'b1; break; end
            if (gnt !== 3'b001) gnt_ok = 1'b0;
        end
        req = '0;
        checks += 4;
        if (!ok)     begin errors++; $display("FAIL single_done_timeout: no done within 2000 cycles"); end
        if (!gnt_ok) begin errors++; $display("FAIL single_gnt_held: gnt dropped during transfer"); end
        if (done !== 3'b001 || err !== 1'b0) begin
            errors++; $display("FAIL single_done: done=%b err=%b want done=001 err=0", done, err);
        end
        if (cs_pulses != 5) begin errors++; $display("FAIL single_cs_count: got %0d want 5", cs_pulses); end
        for (int k = 0; k < 5; k++) begin
            got = (k < byteq.size()) ? byteq[k] : 8'hxx;
            checks++;
            if (got !== exp[k]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", k, got, exp[k]); end
        end
        repeat (3) tick();
        checks++;
        if (doneq.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", doneq.size()); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [7:0]      exp_b [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA1, 8'hA2};
        logic [NREQ-1:0] g;
        logic [7:0]      b;
        do_reset();
        clear_logs();
        msg_data = '0;
        for (int i = 0; i < NREQ; i++) msg_data[i*MW +: 8] = 8'hA0 + 8'(i);
        msg_len = {5'd1, 5'd1, 5'd1};
        req = 3'b111;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (doneq.size() >= 6) break;
        end
        req = '0;
        repeat (4) tick();
        checks++;
        if (doneq.size() != 6) begin errors++; $display("FAIL rr_done_count: got %0d want 6", doneq.size()); end
        for (int k = 0; k < 6; k++) begin
            g = (k < gntq.size()) ? gntq[k] : 'x;
            b = (k < byteq.size()) ? byteq[k] : 8'hxx;
            checks += 2;
            if (g !== exp_g[k]) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, g, exp_g[k]); end
            if (b !== exp_b[k]) begin errors++; $display("FAIL rr_byte%0d: got %h want %h", k, b, exp_b[k]); end
        end
    endtask

    task automatic test_zero_len_clamp();
        logic [7:0] got;
        bit ok;
        clear_logs();
        msg_len[5 +: 5] = 5'd0;
        req = 3'b010;
        tick();
        checks++;
        if (gnt !== 3'b010 || done !== 3'b000) begin
            errors++; $display("FAIL zero_edge1: gnt=%b done=%b want 010/000", gnt, done);
        end
        tick();
        checks++;
        if (done !== 3'b010 || err !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b err=%b want 010/0", done, err);
        end
        req = '0;
        repeat (3) tick();
        checks++;
        if (cs_pulses != 0) begin errors++; $display("FAIL zero_no_cs: got %0d pulses want 0", cs_pulses); end

        clear_logs();
        msg_data[2*MW +: MW] = '0;
        for (int k = 0; k < MAXLEN; k++) msg_data[2*MW + 8*k +: 8] = 8'h10 + 8'(k);
        msg_len[10 +: 5] = 5'd20;
        req = 3'b100;
        wait_done(2000, ok);
        req = '0;
        checks += 2;
        if (!ok) begin errors++; $display("FAIL clamp_done_timeout: no done within 2000 cycles"); end
        if (cs_pulses != 16) begin errors++; $display("FAIL clamp_count: got %0d bytes want 16", cs_pulses); end
        for (int k = 0; k < 16; k++) begin
            got = (k < byteq.size()) ? byteq[k] : 8'hxx;
            checks++;
            if (got !== 8'h10 + 8'(k)) begin
                errors++; $display("FAIL clamp_byte%0d: got %h want %h", k, got, 8'h10 + 8'(k));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int hi;
        bit ok;
        clear_logs();
        auto_en = 1'b0;
        force_busy = 1'b0;
        msg_data[0 +: 16] = 16'hBEEF;
        msg_len[0 +: 5] = 5'd2;
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b001 || tx_cs !== 1'b0) begin
            errors++; $display("FAIL to_edge1: gnt=%b cs=%b want 001/0", gnt, tx_cs);
        end
        hi = 0;
        for (int k = 0; k < BT; k++) begin
            tick();
            if (tx_cs === 1'b1) hi++;
        end
        checks++;
        if (hi != BT) begin errors++; $display("FAIL to_cs_high: got %0d cycles want %0d", hi, BT); end
        tick();
        checks++;
        if (tx_cs !== 1'b0 || done !== 3'b001 || err !== 1'b1) begin
            errors++; $display("FAIL to_abort: cs=%b done=%b err=%b want 0/001/1", tx_cs, done, err);
        end
        req = '0;
        tick();
        checks++;
        if (done !== 3'b000 || err !== 1'b0 || gnt !== 3'b000) begin
            errors++; $display("FAIL to_idle: done=%b err=%b gnt=%b want 000/0/000", done, err, gnt);
        end
        clear_logs();
        auto_en = 1'b1;
        msg_data[MW +: 8] = 8'h77;
        msg_len[5 +: 5] = 5'd1;
        req = 3'b010;
        wait_done(500, ok);
        req = '0;
        checks += 2;
        if (!ok || done !== 3'b010 || err !== 1'b0) begin
            errors++; $display("FAIL to_next: ok=%0d done=%b err=%b want 1/010/0", ok, done, err);
        end
        if (byteq.size() != 1 || byteq[0] !== 8'h77) begin
            errors++; $display("FAIL to_next_byte: count=%0d want one byte 77", byteq.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_busy_start();
        bit cs_lo, ok;
        clear_logs();
        auto_en = 1'b0;
        force_busy = 1'b1;
        msg_data[0 +: 8] = 8'h3C;
        msg_len[0 +: 5] = 5'd1;
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL busy_gnt: got %b want 001", gnt); end
        cs_lo = 1'b1;
        repeat (5) begin
            tick();
            if (tx_cs !== 1'b0) cs_lo = 1'b0;
        end
        checks++;
        if (!cs_lo) begin errors++; $display("FAIL busy_cs_held_low: cs rose while busy"); end
        auto_en = 1'b1;
        tick();
        checks++;
        if (tx_cs !== 1'b1 || tx_tch !== 8'h3C) begin
            errors++; $display("FAIL busy_release: cs=%b tch=%h want 1/3c", tx_cs, tx_tch);
        end
        wait_done(500, ok);
        req = '0;
        checks++;
        if (!ok || err !== 1'b0 || cs_pulses != 1) begin
            errors++; $display("FAIL busy_done: ok=%0d err=%b pulses=%0d want 1/0/1", ok, err, cs_pulses);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5] = '{8'h52, 8'h45, 8'h41, 8'h44, 8'h59};
        logic [7:0] got;
        bit ok;
        clear_logs();
        msg_data[0 +: MW] = '0;
        msg_data[0 +: 40] = 40'h5944414552;
        msg_len[0 +: 5] = 5'd5;
        req = 3'b001;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (cs_pulses >= 3) break;
        end
        checks++;
        if (cs_pulses != 3 || tx_cs !== 1'b1) begin
            errors++; $display("FAIL mid_reach_byte3: pulses=%0d cs=%b want 3/1", cs_pulses, tx_cs);
        end
        reset = 1'b0;
        #1;
        checks += 4;
        if (tx_cs !== 1'b0)   begin errors++; $display("FAIL mid_async_cs: got %b want 0", tx_cs); end
        if (gnt !== 3'b000)   begin errors++; $display("FAIL mid_async_gnt: got %b want 000", gnt); end
        if (done !== 3'b000)  begin errors++; $display("FAIL mid_async_done: got %b want 000", done); end
        if (tx_tch !== 8'h00) begin errors++; $display("FAIL mid_async_tch: got %h want 00", tx_tch); end
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        wait_done(2000, ok);
        req = '0;
        checks += 2;
        if (!ok) begin errors++; $display("FAIL mid_reserve_timeout: no done within 2000 cycles"); end
        if (cs_pulses != 5) begin errors++; $display("FAIL mid_reserve_count: got %0d want 5", cs_pulses); end
        for (int k = 0; k < 5; k++) begin
            got = (k < byteq.size()) ? byteq[k] : 8'hxx;
            checks++;
            if (got !== exp[k]) begin errors++; $display("FAIL mid_byte%0d: got %h want %h", k, got, exp[k]); end
        end
        repeat (3) tick();
    endtask

    initial begin
        req = '0;
        msg_len = '0;
        msg_data = '0;
        auto_en = 1'b1;
        force_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len_clamp();
        test_timeout();
        test_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
